// File: rtl/heartbeat_display_gen.sv
// heartbeat_display_gen: multiplexed active-low seven-segment heartbeat animation.
// A pair of vertical bars expands outward from the centre digits and then either
// contracts back (bounce) or restarts from the centre (wrap). beat_o pulses for one
// cycle whenever the phase returns to 0.
// Optional feature: define HEARTBEAT_DP_EN to add dp_o, an active-low decimal point
// that is lit on every digit for the step period that follows a beat.
module heartbeat_display_gen #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned STEP_W     = 21,
  parameter int unsigned REFRESH_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  mode_i,
  input  logic [1:0]            rate_sel_i,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic [6:0]            sseg_o,
`ifdef HEARTBEAT_DP_EN
  output logic                  beat_o,
  output logic                  dp_o
`else
  output logic                  beat_o
`endif
);

  localparam int unsigned DigW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned Half = NUM_DIGITS / 2;

  localparam logic [DigW-1:0] LastPhase = DigW'(NUM_DIGITS - 1);
  localparam logic [DigW-1:0] OnePhase  = DigW'(1);

  // Segment order {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [6:0] SegBc    = 7'b1111001;
  localparam logic [6:0] SegFe    = 7'b1001111;

  typedef enum logic {StExpand, StContract} state_e;

  state_e                  state_q;
  logic [DigW-1:0]         phase_q;
  logic                    beat_q;
  logic [STEP_W-1:0]       step_cnt_q;
  logic [STEP_W-1:0]       step_mask;
  logic                    step_tick;
  logic [REFRESH_W-1:0]    ref_cnt_q;
  logic [DigW-1:0]         dig_sel_q;
  logic [DigW-1:0]         left_dig;
  logic [DigW-1:0]         right_dig;
  logic [NUM_DIGITS-1:0]   an_d, an_q;
  logic [6:0]              sseg_d, sseg_q;

  // Step tick fires when the low (STEP_W - rate_sel_i) counter bits are all ones.
  always_comb begin
    step_mask = {STEP_W{1'b1}} >> rate_sel_i;
    step_tick = en_i && ((step_cnt_q & step_mask) == step_mask);
  end

  // Free-running step counter, held while the animation is frozen.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      step_cnt_q <= '0;
    end else if (en_i) begin
      step_cnt_q <= step_cnt_q + STEP_W'(1);
    end
  end

  // Animation FSM: advances phase on each step tick and flags returns to 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StExpand;
      phase_q <= '0;
      beat_q  <= 1'b0;
    end else begin
      beat_q <= 1'b0;
      if (step_tick) begin
        case (state_q)
          StExpand: begin
            if (phase_q != LastPhase) begin
              phase_q <= phase_q + OnePhase;
            end else if (mode_i || (phase_q == OnePhase)) begin
              // Wrap, or a two-digit bounce whose contraction lands straight on 0.
              phase_q <= '0;
              beat_q  <= 1'b1;
            end else begin
              state_q <= StContract;
              phase_q <= phase_q - OnePhase;
            end
          end
          StContract: begin
            if (mode_i || (phase_q == OnePhase)) begin
              state_q <= StExpand;
              phase_q <= '0;
              beat_q  <= 1'b1;
            end else begin
              phase_q <= phase_q - OnePhase;
            end
          end
          default: begin
            state_q <= StExpand;
            phase_q <= '0;
          end
        endcase
      end
    end
  end

  // Display refresh: each digit is held for 2**REFRESH_W cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ref_cnt_q <= '0;
      dig_sel_q <= '0;
    end else begin
      ref_cnt_q <= ref_cnt_q + REFRESH_W'(1);
      if (&ref_cnt_q) begin
        dig_sel_q <= (dig_sel_q == LastPhase) ? '0 : dig_sel_q + OnePhase;
      end
    end
  end

  // Decode the bar pair for the current phase onto the scanned digit.
  always_comb begin
    left_dig  = DigW'(Half) + (phase_q >> 1);
    right_dig = DigW'(Half - 1) - (phase_q >> 1);
    sseg_d    = SegBlank;
    if (dig_sel_q == left_dig) begin
      sseg_d = phase_q[0] ? SegFe : SegBc;
    end else if (dig_sel_q == right_dig) begin
      sseg_d = phase_q[0] ? SegBc : SegFe;
    end
    an_d = ~(NUM_DIGITS'(1) << dig_sel_q);
  end

  // Registered display outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      an_q   <= '1;
      sseg_q <= SegBlank;
    end else begin
      an_q   <= an_d;
      sseg_q <= sseg_d;
    end
  end

  assign an_o   = an_q;
  assign sseg_o = sseg_q;
  assign beat_o = beat_q;

`ifdef HEARTBEAT_DP_EN
  logic ticked_q;
  logic dp_q;

  // Phase 0 only recurs after a beat once the first step has happened.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ticked_q <= 1'b0;
    end else if (step_tick) begin
      ticked_q <= 1'b1;
    end
  end

  // Decimal point lit while the phase sits at 0 following a beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dp_q <= 1'b1;
    end else begin
      dp_q <= !(ticked_q && (phase_q == '0));
    end
  end

  assign dp_o = dp_q;
`endif

endmodule

// File: tb/tb_heartbeat_display_gen.sv
// Testbench for heartbeat_display_gen: vector table, hand sequences, random run
// against a behavioural model of the animation rules.
module tb_heartbeat_display_gen;

  localparam int NumDigits = 4;
  localparam int StepW     = 5;
  localparam int RefreshW  = 1;
  localparam int Half      = NumDigits / 2;

  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [6:0] SegBc    = 7'b1111001;
  localparam logic [6:0] SegFe    = 7'b1001111;

  logic                 clk  = 1'b0;
  logic                 rst  = 1'b1;
  logic                 en   = 1'b0;
  logic                 mode = 1'b0;
  logic [1:0]           rate = 2'd0;
  logic [NumDigits-1:0] an;
  logic [6:0]           sseg;
  logic                 beat;
`ifdef HEARTBEAT_DP_EN
  logic                 dp;
`endif

  heartbeat_display_gen #(
    .NUM_DIGITS (NumDigits),
    .STEP_W     (StepW),
    .REFRESH_W  (RefreshW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .mode_i     (mode),
    .rate_sel_i (rate),
    .an_o       (an),
    .sseg_o     (sseg),
    .beat_o     (beat)
`ifdef HEARTBEAT_DP_EN
    , .dp_o     (dp)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: integer phase, direction, enabled-cycle and refresh-cycle counts.
  int   m_p       = 0;
  bit   m_up      = 1'b1;
  int   m_cnt     = 0;
  int   m_ref     = 0;
  bit   m_dp_flag = 1'b0;
  logic [NumDigits-1:0] exp_an;
  logic [6:0]           exp_seg;
  logic                 exp_beat;
  logic                 exp_dp;

  typedef struct {
    logic                 en;
    logic                 mode;
    logic [1:0]           rate;
    logic [NumDigits-1:0] an;
    logic [6:0]           seg;
    logic                 beat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  // Picture of the whole display for phase p, then pick digit d.
  function automatic logic [6:0] seg_for(input int p, input int d);
    logic [6:0] img [NumDigits];
    for (int i = 0; i < NumDigits; i++) img[i] = SegBlank;
    img[Half + p / 2]     = (p % 2 == 0) ? SegBc : SegFe;
    img[Half - 1 - p / 2] = (p % 2 == 0) ? SegFe : SegBc;
    return img[d];
  endfunction

  task automatic model_edge();
    int dig;
    int per;
    bit tick;
    if (rst) begin
      m_p = 0; m_up = 1'b1; m_cnt = 0; m_ref = 0; m_dp_flag = 1'b0;
      exp_an = '1; exp_seg = SegBlank; exp_beat = 1'b0; exp_dp = 1'b1;
    end else begin
      dig = (m_ref / (1 << RefreshW)) % NumDigits;
      exp_an = '1;
      exp_an[dig] = 1'b0;
      exp_seg = seg_for(m_p, dig);
      exp_dp = ~m_dp_flag;
      exp_beat = 1'b0;
      per = 1 << (StepW - int'(rate));
      tick = en && (m_cnt % per == per - 1);
      if (tick) begin
        if (mode && (!m_up || m_p == NumDigits - 1)) begin
          m_p = 0;
          m_up = 1'b1;
        end else if (m_up && m_p < NumDigits - 1) begin
          m_p++;
        end else begin
          m_up = 1'b0;
          m_p--;
          if (m_p == 0) m_up = 1'b1;
        end
        exp_beat = (m_p == 0);
        m_dp_flag = exp_beat;
      end
      if (en) m_cnt++;
      m_ref++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model_an", an, exp_an);
    check("model_sseg", sseg, exp_seg);
    check("model_beat", beat, exp_beat);
`ifdef HEARTBEAT_DP_EN
    check("model_dp", dp, exp_dp);
`endif
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [NumDigits-1:0] seen;

    vecs[0] = '{1'b1, 1'b0, 2'd0, 4'b1110, SegBlank, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 2'd0, 4'b1110, SegBlank, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 2'd0, 4'b1101, SegFe,    1'b0};
    vecs[3] = '{1'b1, 1'b0, 2'd0, 4'b1101, SegFe,    1'b0};
    vecs[4] = '{1'b1, 1'b0, 2'd0, 4'b1011, SegBc,    1'b0};
    vecs[5] = '{1'b1, 1'b0, 2'd0, 4'b1011, SegBc,    1'b0};
    vecs[6] = '{1'b1, 1'b0, 2'd0, 4'b0111, SegBlank, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 2'd0, 4'b0111, SegBlank, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 2'd0, 4'b1110, SegBlank, 1'b0};

    // Reset values, then the scan of the centre bars right after release.
    do_reset(3);
    check("reset_an", an, 4'hF);
    check("reset_sseg", sseg, SegBlank);
    check("reset_beat", beat, 1'b0);
    for (int i = 0; i < 9; i++) begin
      en = vecs[i].en; mode = vecs[i].mode; rate = vecs[i].rate;
      cycle();
      check("vec_an", an, vecs[i].an);
      check("vec_sseg", sseg, vecs[i].seg);
      check("vec_beat", beat, vecs[i].beat);
    end

    // Bounce at period 4: phase 0,1,2,3,2,1,0 -> first beat right after edge 24.
    do_reset(2);
    en = 1'b1; mode = 1'b0; rate = 2'd3;
    for (int k = 1; k <= 30; k++) begin
      cycle();
      check("bounce_beat", beat, (k == 24));
    end

    // Switch to wrap while contracting at phase 2, then wrap 0,1,2,3,0.
    do_reset(2);
    en = 1'b1; rate = 2'd3;
    for (int k = 1; k <= 40; k++) begin
      mode = (k >= 17);
      cycle();
      check("switch_beat", beat, (k == 20 || k == 36));
    end

    // Reset in the middle of a contraction at phase 2.
    do_reset(2);
    en = 1'b1; mode = 1'b0; rate = 2'd3;
    repeat (18) cycle();
    rst = 1'b1; en = 1'b0;
    cycle();
    check("midrst_an", an, 4'hF);
    check("midrst_sseg", sseg, SegBlank);
    check("midrst_beat", beat, 1'b0);
    rst = 1'b0; en = 1'b1;
    cycle();
    check("restart_an", an, 4'b1110);
    repeat (12) cycle();

    // Frozen animation: phase holds while the scan keeps visiting every digit.
    en = 1'b0;
    seen = '0;
    repeat (100) begin
      cycle();
      seen = seen | ~an;
    end
    check("freeze_scan", seen, 4'hF);

    // Randomised run against the model.
    rate = 2'd2;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      if ($urandom_range(0, 99) == 0) rate = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
